// File: rtl/im_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding
// and the default geometry of a program load.
package im_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    CHECK = 3'd5
  } state_t;

  localparam int IM_BYTE_W    = 8;
  localparam int IM_ADDR_W    = 4;
  localparam int IM_NUM_INSTR = 16;

endpackage

// File: rtl/im_byte_packer.sv
// Assembles incoming bytes MSB-first into one instruction word and tracks
// which byte of the word is expected next. word_full flags the transfer
// that completes a word.
module im_byte_packer
  import im_pkg::*;
#(
  parameter int BYTE_W          = IM_BYTE_W,
  parameter int BYTES_PER_INSTR = 2,
  parameter int INSTR_W         = BYTE_W * BYTES_PER_INSTR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               take,
  input  logic [BYTE_W-1:0]  in_data,
  output logic [INSTR_W-1:0] word,
  output logic               word_full
);

  localparam logic [2:0] LAST_IDX = 3'(BYTES_PER_INSTR - 1);

  logic [2:0]         idx_q, idx_d;
  logic [INSTR_W-1:0] word_q, word_d;

  assign word_full = take && (idx_q == LAST_IDX);
  assign word      = word_q;

  // Shift each accepted byte in at the bottom so the first byte ends up on top.
  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clr) begin
      idx_d = 3'd0;
    end else if (take) begin
      word_d = (word_q << BYTE_W) | INSTR_W'(in_data);
      idx_d  = word_full ? 3'd0 : idx_q + 3'd1;
    end
  end

  // Index and assembly register; reset discards any partial word.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= 3'd0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/im_loader_fsm.sv
// Program loader sitting in front of the instruction counter: takes a byte
// stream over valid/ready, packs it into instruction words, writes each word
// to IM at the counter's address and steps the counter once per write.
// Optional trailing checksum byte is enabled with IM_LOADER_CHECKSUM_EN.
module im_loader_fsm
  import im_pkg::*;
#(
  parameter int BYTE_W          = IM_BYTE_W,
  parameter int BYTES_PER_INSTR = 2,
  parameter int INSTR_W         = BYTE_W * BYTES_PER_INSTR,
  parameter int ADDR_W          = IM_ADDR_W,
  parameter int NUM_INSTR       = IM_NUM_INSTR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [BYTE_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ADDR_W-1:0]  cuenta,
  output logic               cnt_rst,
  output logic               cnt_ena,
  output logic               im_we,
  output logic [ADDR_W-1:0]  im_addr,
  output logic [INSTR_W-1:0] im_wdata,
  output logic               busy,
  output logic               done,
  output logic               chk_err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_INSTR - 1);

  state_t state_q, state_d;
  logic   in_ready_q, in_ready_d;
  logic   cnt_rst_q, cnt_rst_d;
  logic   cnt_ena_q, cnt_ena_d;
  logic   im_we_q, im_we_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;
  logic   take, word_full;

  // Bytes are only packed in LOAD; the checksum byte in CHECK bypasses the packer.
  assign take = in_valid && in_ready_q && (state_q == LOAD);

  im_byte_packer #(
    .BYTE_W          (BYTE_W),
    .BYTES_PER_INSTR (BYTES_PER_INSTR),
    .INSTR_W         (INSTR_W)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clr       (state_q == CLEAR),
    .take      (take),
    .in_data   (in_data),
    .word      (im_wdata),
    .word_full (word_full)
  );

  assign im_addr  = cuenta;
  assign in_ready = in_ready_q;
  assign cnt_rst  = cnt_rst_q;
  assign cnt_ena  = cnt_ena_q;
  assign im_we    = im_we_q;
  assign busy     = busy_q;
  assign done     = done_q;

  // Next state, plus output decodes of the next state so strobes are registered.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = CLEAR;
      CLEAR: state_d = LOAD;
      LOAD:  if (word_full) state_d = WRITE;
      WRITE: begin
        if (cuenta == LAST_ADDR) begin
`ifdef IM_LOADER_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = LOAD;
        end
      end
`ifdef IM_LOADER_CHECKSUM_EN
      CHECK: if (in_valid && in_ready_q) state_d = DONE;
`endif
      DONE:  if (start) state_d = CLEAR;
      default: state_d = IDLE;
    endcase

`ifdef IM_LOADER_CHECKSUM_EN
    in_ready_d = (state_d == LOAD) || (state_d == CHECK);
    busy_d     = (state_d == CLEAR) || (state_d == LOAD) ||
                 (state_d == WRITE) || (state_d == CHECK);
`else
    in_ready_d = (state_d == LOAD);
    busy_d     = (state_d == CLEAR) || (state_d == LOAD) || (state_d == WRITE);
`endif
    cnt_rst_d = (state_d == CLEAR);
    cnt_ena_d = (state_d == WRITE);
    im_we_d   = (state_d == WRITE);
    done_d    = (state_d == DONE);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
      cnt_rst_q  <= 1'b0;
      cnt_ena_q  <= 1'b0;
      im_we_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      cnt_rst_q  <= cnt_rst_d;
      cnt_ena_q  <= cnt_ena_d;
      im_we_q    <= im_we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

`ifdef IM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] xor_q, xor_d;
  logic              chk_err_q, chk_err_d;

  assign chk_err = chk_err_q;

  // Running XOR of payload bytes; the byte taken in CHECK is compared against it.
  always_comb begin
    xor_d     = xor_q;
    chk_err_d = chk_err_q;
    if (state_d == CLEAR) begin
      xor_d     = '0;
      chk_err_d = 1'b0;
    end else if (take) begin
      xor_d = xor_q ^ in_data;
    end else if (state_q == CHECK && in_valid && in_ready_q) begin
      chk_err_d = (in_data != xor_q);
    end
  end

  // Checksum accumulator and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      xor_q     <= '0;
      chk_err_q <= 1'b0;
    end else begin
      xor_q     <= xor_d;
      chk_err_q <= chk_err_d;
    end
  end
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_im_loader_fsm.sv
// Bench for im_loader_fsm: a cycle table for reset, basic load, stalls and
// reset mid-word, then randomized full loads checked against a byte-list model.
module tb_im_loader_fsm;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_ready;
  logic [7:0]  in_data;
  logic [3:0]  cuenta;
  logic        cnt_rst, cnt_ena, im_we, busy, done, chk_err;
  logic [3:0]  im_addr;
  logic [15:0] im_wdata;

  always #5 clk = ~clk;

  im_loader_fsm dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .cuenta(cuenta),
    .cnt_rst(cnt_rst), .cnt_ena(cnt_ena), .im_we(im_we),
    .im_addr(im_addr), .im_wdata(im_wdata), .busy(busy),
    .done(done), .chk_err(chk_err)
  );

  // Model of the downstream 4-bit instruction counter.
  always @(posedge clk) begin
    if (rst || cnt_rst) cuenta <= 4'd0;
    else if (cnt_ena)   cuenta <= cuenta + 4'd1;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // {in_ready, im_we, cnt_ena, cnt_rst, busy, done, chk_err}
  localparam logic [6:0] Z = 7'b0000000;
  localparam logic [6:0] C = 7'b0001100;
  localparam logic [6:0] L = 7'b1000100;
  localparam logic [6:0] W = 7'b0110100;

  typedef struct {
    logic       r, s, v;
    logic [7:0] d;
    logic [6:0] o;
    logic [15:0] wd;
    logic [3:0] ad;
  } vec_t;

  function automatic vec_t mk(logic r, logic s, logic v, logic [7:0] d,
                              logic [6:0] o, logic [15:0] wd, logic [3:0] ad);
    vec_t t;
    t.r = r; t.s = s; t.v = v; t.d = d; t.o = o; t.wd = wd; t.ad = ad;
    return t;
  endfunction

  vec_t tbl[21];

  // Random-load model state: the bytes offered, in order.
  logic [7:0] bytes[33];
  bit         mon_en = 1'b0;
  int         nwr, nena;

  // Each write must carry the next assembled word at the next address.
  always @(negedge clk) begin
    if (mon_en) begin
      check("ena_with_we", {31'd0, cnt_ena}, {31'd0, im_we});
      check("ready_when_idle_strobe", {31'd0, in_ready & (im_we | cnt_rst | done)}, 32'd0);
      if (cnt_ena) nena++;
      if (im_we) begin
        if (nwr < 16) begin
          check("rand_addr", {28'd0, im_addr}, nwr);
          check("rand_word", {16'd0, im_wdata}, {16'd0, bytes[2*nwr], bytes[2*nwr+1]});
        end else begin
          check("extra_write", nwr, 15);
        end
        nwr++;
      end
    end
  end

  task automatic run_load();
    int          nb, idx, cyc;
    logic [7:0]  x;
    logic        exp_err;
    x = 8'h00;
    for (int i = 0; i < 32; i++) begin
      bytes[i] = 8'($urandom);
      x = x ^ bytes[i];
    end
    exp_err = 1'b0;
    nb = 32;
`ifdef IM_LOADER_CHECKSUM_EN
    exp_err   = 1'($urandom);
    bytes[32] = exp_err ? (x ^ 8'h01) : x;
    nb = 33;
`endif
    @(negedge clk);
    start = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("clear_cnt_rst", {31'd0, cnt_rst}, 1);
    check("clear_done_low", {31'd0, done}, 0);
    check("clear_busy", {31'd0, busy}, 1);
    check("clear_chk_err", {31'd0, chk_err}, 0);
    start = 1'b0;
    nwr = 0; nena = 0; mon_en = 1'b1;
    idx = 0; cyc = 0;
    while (idx < nb && cyc < 2000) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 2) != 0);
      in_data  = bytes[idx];
      start    = ($urandom_range(0, 5) == 0);
      if (in_valid && in_ready) idx++;
      cyc++;
    end
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    check("feed_all_bytes", idx, nb);
    cyc = 0;
    while (!done && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check("load_done", {31'd0, done}, 1);
    check("load_busy_low", {31'd0, busy}, 0);
    check("load_ready_low", {31'd0, in_ready}, 0);
    check("write_count", nwr, 16);
    check("ena_count", nena, 16);
    check("chk_err", {31'd0, chk_err}, {31'd0, exp_err});
    mon_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b1; in_data = 8'h00;

    tbl[0]  = mk(1, 0, 1, 8'h00, Z, 16'h0000, 4'd0);
    tbl[1]  = mk(1, 0, 1, 8'h00, Z, 16'h0000, 4'd0);
    tbl[2]  = mk(0, 1, 0, 8'h00, Z, 16'h0000, 4'd0);
    tbl[3]  = mk(0, 0, 0, 8'h00, C, 16'h0000, 4'd0);
    tbl[4]  = mk(0, 0, 1, 8'h12, L, 16'h0000, 4'd0);
    tbl[5]  = mk(0, 0, 1, 8'h34, L, 16'h0000, 4'd0);
    tbl[6]  = mk(0, 0, 0, 8'h00, W, 16'h1234, 4'd0);
    tbl[7]  = mk(0, 0, 1, 8'hAB, L, 16'h0000, 4'd0);
    tbl[8]  = mk(0, 0, 0, 8'h00, L, 16'h0000, 4'd0);
    tbl[9]  = mk(0, 0, 0, 8'h00, L, 16'h0000, 4'd0);
    tbl[10] = mk(0, 0, 1, 8'hCD, L, 16'h0000, 4'd0);
    tbl[11] = mk(0, 0, 0, 8'h00, W, 16'hABCD, 4'd1);
    tbl[12] = mk(0, 1, 1, 8'h12, L, 16'h0000, 4'd0);
    tbl[13] = mk(1, 0, 0, 8'h00, L, 16'h0000, 4'd0);
    tbl[14] = mk(0, 0, 0, 8'h00, Z, 16'h0000, 4'd0);
    tbl[15] = mk(0, 1, 0, 8'h00, Z, 16'h0000, 4'd0);
    tbl[16] = mk(0, 0, 0, 8'h00, C, 16'h0000, 4'd0);
    tbl[17] = mk(0, 0, 1, 8'h56, L, 16'h0000, 4'd0);
    tbl[18] = mk(0, 0, 1, 8'h78, L, 16'h0000, 4'd0);
    tbl[19] = mk(0, 0, 0, 8'h00, W, 16'h5678, 4'd0);
    tbl[20] = mk(0, 0, 0, 8'h00, L, 16'h0000, 4'd0);

    @(posedge clk);
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      check($sformatf("row%0d_ctl", i),
            {25'd0, in_ready, im_we, cnt_ena, cnt_rst, busy, done, chk_err},
            {25'd0, tbl[i].o});
      if (tbl[i].o[5]) begin
        check($sformatf("row%0d_wdata", i), {16'd0, im_wdata}, {16'd0, tbl[i].wd});
        check($sformatf("row%0d_addr", i), {28'd0, im_addr}, {28'd0, tbl[i].ad});
      end
      rst = tbl[i].r; start = tbl[i].s; in_valid = tbl[i].v; in_data = tbl[i].d;
    end

    @(negedge clk);
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("reset_idle_ctl", {25'd0, in_ready, im_we, cnt_ena, cnt_rst, busy, done, chk_err}, 32'd0);

    run_load();
    run_load();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
